product_splitter: RTL and testbench

- Takes a 2*NBits multiplier product and splits it back into sign plus magnitude.
- Performs the inverse of the result-select stage: it undoes the two's-complement choice on the output path.
- Streams the magnitude to a downstream NBits-wide consumer as two halves, low half first, over a valid/ready handshake.
- Sits between the multiplier result path and the NBits-wide output bus or display path.

---
 rtl/product_splitter.sv | 117 +++++++++++
 tb/tb_product_splitter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/product_splitter.sv
// Splits a 2*NBits product into sign plus magnitude and streams the magnitude
// to an NBits-wide consumer as two halves (low first) over valid/ready.
module product_splitter #(
    parameter int NBits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Load,
    input  logic [2*NBits-1:0] Product,
    input  logic               Signed_Mode,
    input  logic               Ready,
    output logic               Busy,
    output logic               Sign,
    output logic [NBits-1:0]   Half,
    output logic               Half_Sel,
    output logic               Valid,
    output logic               Done
);

    localparam int PW = 2 * NBits;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mag_q, mag_d;
    logic              sign_q, sign_d;
    logic [NBits-1:0]  half_q, half_d;
    logic              sel_q, sel_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            half_q  <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            half_q  <= half_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Load) begin
                    state_d = SEND_LO;
                    // Undo the two's-complement selection; the most-negative
                    // value maps to 2^(PW-1), which still fits unsigned.
                    if (Signed_Mode && Product[PW-1]) begin
                        mag_d  = ~Product + PW'(1);
                        sign_d = 1'b1;
                    end else begin
                        mag_d  = Product;
                        sign_d = 1'b0;
                    end
                end
            end
            SEND_LO: if (Ready) state_d = SEND_HI;
            SEND_HI: if (Ready) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        half_d  = '0;
        sel_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_d)
            SEND_LO: begin
                half_d  = mag_d[NBits-1:0];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            SEND_HI: begin
                half_d  = mag_d[PW-1:NBits];
                sel_d   = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    assign Busy     = busy_q;
    assign Sign     = sign_q;
    assign Half     = half_q;
    assign Half_Sel = sel_q;
    assign Valid    = valid_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_product_splitter.sv
// Scoreboard bench for product_splitter: stimulus pushes expected halves,
// a negedge monitor pops and compares on every accepted Valid&Ready beat.
module tb_product_splitter;

    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          Load;
    logic [15:0]   Product;
    logic          Signed_Mode;
    logic          Ready;
    logic          Busy, Sign, Half_Sel, Valid, Done;
    logic [NB-1:0] Half;

    int errors = 0;
    int checks = 0;
    int exp_done = 0;
    int done_seen = 0;

    typedef struct packed {
        logic          sel;
        logic          sign;
        logic [NB-1:0] half;
    } beat_t;

    beat_t exp_q[$];

    product_splitter #(.NBits(NB)) dut (
        .clk(clk), .reset(reset), .Load(Load), .Product(Product),
        .Signed_Mode(Signed_Mode), .Ready(Ready), .Busy(Busy), .Sign(Sign),
        .Half(Half), .Half_Sel(Half_Sel), .Valid(Valid), .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] h, input logic s, input logic sg);
        beat_t b;
        b.sel  = s;
        b.sign = sg;
        b.half = h;
        exp_q.push_back(b);
    endtask

    task automatic load(input logic [15:0] p, input logic sm);
        Load        = 1'b1;
        Product     = p;
        Signed_Mode = sm;
        step();
        Load        = 1'b0;
    endtask

    // Monitor: accepted beats are compared against the scoreboard.
    always @(negedge clk) begin
        if (!reset && Done) done_seen++;
        if (!reset && Valid && Ready) begin
            beat_t got;
            got = {Half_Sel, Sign, Half};
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat{sel,sign,half}", 32'(got), 32'(e));
            end
        end
    end

    initial begin
        reset = 1'b1; Load = 1'b0; Product = '0; Signed_Mode = 1'b0; Ready = 1'b0;
        #1;
        chk("rst_outputs", {26'd0, Busy, Sign, Half_Sel, Valid, Done, |Half}, 32'd0);
        step(); step();
        reset = 1'b0;
        step();

        // 1: unsigned 0x1234, directed latency checks
        Ready = 1'b1;
        push(8'h34, 1'b0, 1'b0); push(8'h12, 1'b1, 1'b0); exp_done++;
        load(16'h1234, 1'b0);
        chk("t1_lo", {Valid, Half_Sel, Sign, Busy, 4'd0, Half}, {4'b1001, 4'd0, 8'h34});
        step();
        chk("t1_hi", {Valid, Half_Sel, Sign, Busy, 4'd0, Half}, {4'b1101, 4'd0, 8'h12});
        step();
        chk("t1_done", {Done, Valid, Busy, Half_Sel, 4'd0, Half}, {4'b1000, 4'd0, 8'h00});
        step();
        chk("t1_idle_done_low", 32'(Done), 32'd0);

        // 2: signed 0xFFFE -> magnitude 2, Done on third cycle after Load
        push(8'h02, 1'b0, 1'b1); push(8'h00, 1'b1, 1'b1); exp_done++;
        load(16'hFFFE, 1'b1);
        step(); step();
        chk("t2_done_lat", {31'd0, Done}, 32'd1);
        chk("t2_sign_held", 32'(Sign), 32'd1);
        step();

        // 3: most-negative input, signed then unsigned
        push(8'h00, 1'b0, 1'b1); push(8'h80, 1'b1, 1'b1); exp_done++;
        load(16'h8000, 1'b1);
        step(); step(); step();
        push(8'h00, 1'b0, 1'b0); push(8'h80, 1'b1, 1'b0); exp_done++;
        load(16'h8000, 1'b0);
        step(); step(); step();

        // 4: stall in SEND_LO, Load while busy ignored
        Ready = 1'b0;
        push(8'h34, 1'b0, 1'b0); push(8'h12, 1'b1, 1'b0); exp_done++;
        load(16'h1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall", {Valid, Busy, Half_Sel, 5'd0, Half}, {3'b110, 5'd0, 8'h34});
            if (i == 1) begin
                load(16'hAAAA, 1'b1);
            end else begin
                step();
            end
        end
        Ready = 1'b1;
        step();
        chk("t4_hi", {Valid, Half_Sel, 6'd0, Half}, {2'b11, 6'd0, 8'h12});
        step();
        chk("t4_done_sign", {30'd0, Done, Sign}, 32'b10);
        step();

        // 5: reset asserted while in SEND_HI aborts without Done
        push(8'h02, 1'b0, 1'b1);
        load(16'hFFFE, 1'b1);
        step();
        Ready = 1'b0;
        chk("t5_in_hi", {30'd0, Valid, Half_Sel}, 32'b11);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_rst", {26'd0, Busy, Sign, Half_Sel, Valid, Done, |Half}, 32'd0);
        step();
        reset = 1'b0;
        step(); step(); step();
        chk("t5_no_done", done_seen, exp_done);
        Ready = 1'b1;
        push(8'hFF, 1'b0, 1'b0); push(8'h00, 1'b1, 1'b0); exp_done++;
        load(16'h00FF, 1'b0);
        step(); step(); step();

        // 6: back-to-back Load in the Done cycle
        push(8'h34, 1'b0, 1'b0); push(8'h12, 1'b1, 1'b0); exp_done++;
        load(16'h1234, 1'b0);
        step(); step();
        chk("t6_done", {31'd0, Done}, 32'd1);
        push(8'hFF, 1'b0, 1'b0); push(8'h00, 1'b1, 1'b0); exp_done++;
        load(16'h00FF, 1'b0);
        chk("t6_b2b_lo", {Valid, Half_Sel, 6'd0, Half}, {2'b10, 6'd0, 8'hFF});
        step(); step(); step();

        chk("sb_empty", exp_q.size(), 32'd0);
        chk("done_count", done_seen, exp_done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
